fft8_sample_loader: RTL

Input stage in front of the 8-point FFT core. It collects one frame of eight complex 8-bit samples from a byte-wide valid/ready stream and presents them to the FFT core as a stable, parallel 128-bit frame. It then tracks the core's fixed pipeline latency and raises `result_valid` when the core outputs correspond to that frame. It holds off the next frame until downstream acknowledges the result.

---
 rtl/fft8_sample_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fft8_sample_loader.sv
// -----------------------------------------------------------------------------
// fft8_sample_loader
//
// Input stage for the 8-point FFT core. Gathers one frame of NSAMP complex
// 8-bit samples (2*NSAMP bytes) from a byte-wide valid/ready stream into a
// shadow register, then commits the whole frame at once onto x_flat. x_flat is
// therefore stable while the next frame fills. After a commit the block counts
// the core's pipeline latency and raises result_valid when the core outputs
// belong to the committed frame. It holds that result until res_ack. Only the
// committing byte of the next frame waits for the acknowledge.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   in_data       sample byte
//   in_valid      in_data is valid this cycle
//   in_sof        start of frame: the current byte is byte 0
//   in_ready      a byte is accepted this cycle (depends on registers only)
//   x_flat        committed frame; byte i sits at [8i+7:8i], x0_re first
//   frame_valid   one-cycle pulse, x_flat was updated on the previous edge
//   result_valid  core outputs belong to the last frame; held until res_ack
//   res_ack       downstream consumed the result
//   sync_err      sticky: a partial frame was dropped by a mid-frame in_sof
// -----------------------------------------------------------------------------
module fft8_sample_loader #(
    parameter int NSAMP       = 8,
    parameter int FFT_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [16*NSAMP-1:0]   x_flat,
    output logic                  frame_valid,
    output logic                  result_valid,
    input  logic                  res_ack,
    output logic                  sync_err
);

    localparam int FBYTES = 2 * NSAMP;
    localparam int BW     = $clog2(FBYTES);
    localparam int SW     = 8 * (FBYTES - 1);
    localparam int LW     = $clog2(FFT_LATENCY + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(FBYTES - 1);

    logic [BW-1:0]          bcnt_r,         bcnt_nxt_s;
    logic [SW-1:0]          shadow_r,       shadow_nxt_s;
    logic [16*NSAMP-1:0]    x_flat_r,       x_flat_nxt_s;
    logic [LW-1:0]          lcnt_r,         lcnt_nxt_s;
    logic                   pending_r,      pending_nxt_s;
    logic                   frame_valid_r,  frame_valid_nxt_s;
    logic                   result_valid_r, result_valid_nxt_s;
    logic                   sync_err_r,     sync_err_nxt_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   commit_s;
    logic                   ack_s;

    // State register: everything clears immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_r         <= {BW{1'b0}};
            shadow_r       <= {SW{1'b0}};
            x_flat_r       <= {(16*NSAMP){1'b0}};
            lcnt_r         <= {LW{1'b0}};
            pending_r      <= 1'b0;
            frame_valid_r  <= 1'b0;
            result_valid_r <= 1'b0;
            sync_err_r     <= 1'b0;
        end else begin
            bcnt_r         <= bcnt_nxt_s;
            shadow_r       <= shadow_nxt_s;
            x_flat_r       <= x_flat_nxt_s;
            lcnt_r         <= lcnt_nxt_s;
            pending_r      <= pending_nxt_s;
            frame_valid_r  <= frame_valid_nxt_s;
            result_valid_r <= result_valid_nxt_s;
            sync_err_r     <= sync_err_nxt_s;
        end
    end

    // Next-state logic: byte capture, commit, latency tracking, result handshake
    always_comb begin
        bcnt_nxt_s         = bcnt_r;
        shadow_nxt_s       = shadow_r;
        x_flat_nxt_s       = x_flat_r;
        lcnt_nxt_s         = lcnt_r;
        pending_nxt_s      = pending_r;
        result_valid_nxt_s = result_valid_r;
        sync_err_nxt_s     = sync_err_r;
        frame_valid_nxt_s  = 1'b0;
        commit_s           = 1'b0;

        accept_s = in_valid && in_ready_s;
        ack_s    = res_ack && result_valid_r;

        if (accept_s) begin
            if (in_sof) begin
                // A sof byte always restarts the frame, including at the last
                // slot, where it aborts rather than commits.
                shadow_nxt_s[7:0] = in_data;
                bcnt_nxt_s        = BW'(1);
                if (bcnt_r != {BW{1'b0}}) begin
                    sync_err_nxt_s = 1'b1;
                end else begin
                    sync_err_nxt_s = sync_err_r;
                end
            end else if (bcnt_r == LAST_IDX) begin
                commit_s          = 1'b1;
                x_flat_nxt_s      = {in_data, shadow_r};
                bcnt_nxt_s        = {BW{1'b0}};
                frame_valid_nxt_s = 1'b1;
            end else begin
                shadow_nxt_s[8*int'(bcnt_r) +: 8] = in_data;
                bcnt_nxt_s = bcnt_r + BW'(1);
            end
        end else begin
            bcnt_nxt_s = bcnt_r;
        end

        // The latency counter is loaded on commit and runs down to zero. The
        // result flag rises on the edge that leaves it at zero.
        if (commit_s) begin
            lcnt_nxt_s = LW'(FFT_LATENCY);
        end else if (lcnt_r != {LW{1'b0}}) begin
            lcnt_nxt_s = lcnt_r - LW'(1);
        end else begin
            lcnt_nxt_s = lcnt_r;
        end

        if (lcnt_r == LW'(1)) begin
            result_valid_nxt_s = 1'b1;
        end else if (ack_s) begin
            result_valid_nxt_s = 1'b0;
        end else begin
            result_valid_nxt_s = result_valid_r;
        end

        // Commit and ack cannot coincide: in_ready blocks a commit while pending.
        if (commit_s) begin
            pending_nxt_s = 1'b1;
        end else if (ack_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Outputs: in_ready depends only on registers. An ack in the same cycle as
    // the last byte does not bypass the stall.
    always_comb begin
        in_ready_s   = !((bcnt_r == LAST_IDX) && pending_r);
        in_ready     = in_ready_s;
        x_flat       = x_flat_r;
        frame_valid  = frame_valid_r;
        result_valid = result_valid_r;
        sync_err     = sync_err_r;
    end

endmodule
